// File: rtl/calendar_bcd_counter.sv
// calendar_bcd_counter
//   Day/month/year BCD calendar counter covering 01/01/00 .. 31/12/99.
//   The counter advances one day per day_inc pulse and applies the real month lengths.
//   A parallel date load is validated before it is applied.
//   Optional feature macro: CAL_LEAP_EN. When it is defined, February has 29 days in
//   2-digit leap years. When it is undefined, February always has 28 days.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   day_inc    in   advance date by one day (level-sampled every cycle)
//   load       in   load ld_day/ld_mon/ld_year (has priority over day_inc)
//   ld_day     in   BCD day   {tens, ones}
//   ld_mon     in   BCD month {tens, ones}
//   ld_year    in   BCD year  {tens, ones}
//   day_1..year_10  out  registered BCD digits
//   year_wrap  out  one-cycle pulse on the 99->00 rollover
//   load_err   out  one-cycle pulse when a load is rejected
module calendar_bcd_counter #(
  parameter logic [7:0] RST_YEAR = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       day_inc,
  input  logic       load,
  input  logic [7:0] ld_day,
  input  logic [7:0] ld_mon,
  input  logic [7:0] ld_year,
  output logic [3:0] day_1,
  output logic [3:0] day_10,
  output logic [3:0] mon_1,
  output logic [3:0] mon_10,
  output logic [3:0] year_1,
  output logic [3:0] year_10,
  output logic       year_wrap,
  output logic       load_err
);

  logic [7:0] r_day, r_mon, r_year;
  logic       r_year_wrap, r_load_err;

  logic [7:0] w_day_d, w_mon_d, w_year_d;
  logic       w_year_wrap_d, w_load_err_d;
  logic       w_cur_leap, w_ld_leap;
  logic [7:0] w_cur_len, w_ld_len;
  logic       w_ld_nib_ok, w_ld_mon_ok, w_ld_day_ok, w_ld_ok;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Month length returned as a BCD byte so it compares directly against the BCD day.
  function automatic logic [7:0] month_len(input logic [7:0] mon, input logic leap);
    case (mon)
      8'h04, 8'h06, 8'h09, 8'h11: month_len = 8'h30;
      8'h02:                      month_len = leap ? 8'h29 : 8'h28;
      default:                    month_len = 8'h31;
    endcase
  endfunction

`ifdef CAL_LEAP_EN
  // 2-digit leap rule: a year is a leap year when the BCD year is a multiple of 4.
  // With an even tens digit, the ones digit must be 0, 4 or 8.
  // With an odd tens digit, the ones digit must be 2 or 6.
  function automatic logic is_leap(input logic tens_odd, input logic [3:0] ones);
    if (tens_odd) is_leap = (ones == 4'd2) || (ones == 4'd6);
    else          is_leap = (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
  endfunction

  assign w_cur_leap = is_leap(r_year[4], r_year[3:0]);
  assign w_ld_leap  = is_leap(ld_year[4], ld_year[3:0]);
`else
  assign w_cur_leap = 1'b0;
  assign w_ld_leap  = 1'b0;
`endif

  assign w_cur_len = month_len(r_mon, w_cur_leap);
  assign w_ld_len  = month_len(ld_mon, w_ld_leap);

  // Once every nibble is known to be at most 9, BCD bytes compare correctly as plain unsigned values.
  assign w_ld_nib_ok = (ld_day[7:4] <= 4'd9) && (ld_day[3:0] <= 4'd9) &&
                       (ld_mon[7:4] <= 4'd9) && (ld_mon[3:0] <= 4'd9) &&
                       (ld_year[7:4] <= 4'd9) && (ld_year[3:0] <= 4'd9);
  assign w_ld_mon_ok = (ld_mon >= 8'h01) && (ld_mon <= 8'h12);
  assign w_ld_day_ok = (ld_day >= 8'h01) && (ld_day <= w_ld_len);
  assign w_ld_ok     = w_ld_nib_ok && w_ld_mon_ok && w_ld_day_ok;

  always_comb begin
    w_day_d       = r_day;
    w_mon_d       = r_mon;
    w_year_d      = r_year;
    w_year_wrap_d = 1'b0;
    w_load_err_d  = 1'b0;
    if (load) begin
      // A load always consumes the cycle, so a coincident day_inc is dropped.
      if (w_ld_ok) begin
        w_day_d  = ld_day;
        w_mon_d  = ld_mon;
        w_year_d = ld_year;
      end else begin
        w_load_err_d = 1'b1;
      end
    end else if (day_inc) begin
      if (r_day == w_cur_len) begin
        w_day_d = 8'h01;
        if (r_mon == 8'h12) begin
          w_mon_d = 8'h01;
          if (r_year == 8'h99) begin
            w_year_d      = 8'h00;
            w_year_wrap_d = 1'b1;
          end else begin
            w_year_d = bcd_inc(r_year);
          end
        end else begin
          w_mon_d = bcd_inc(r_mon);
        end
      end else begin
        w_day_d = bcd_inc(r_day);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_day       <= 8'h01;
      r_mon       <= 8'h01;
      r_year      <= RST_YEAR;
      r_year_wrap <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_day       <= w_day_d;
      r_mon       <= w_mon_d;
      r_year      <= w_year_d;
      r_year_wrap <= w_year_wrap_d;
      r_load_err  <= w_load_err_d;
    end
  end

  assign day_1     = r_day[3:0];
  assign day_10    = r_day[7:4];
  assign mon_1     = r_mon[3:0];
  assign mon_10    = r_mon[7:4];
  assign year_1    = r_year[3:0];
  assign year_10   = r_year[7:4];
  assign year_wrap = r_year_wrap;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_calendar_bcd_counter.sv
// Testbench for calendar_bcd_counter.
// The reference model keeps the date as plain integers: day, month and year 0..99.
// The model is converted to BCD only when it is compared against the DUT outputs.
module tb_calendar_bcd_counter;

  logic       clk;
  logic       rst_n;
  logic       day_inc;
  logic       load;
  logic [7:0] ld_day, ld_mon, ld_year;
  logic [3:0] day_1, day_10, mon_1, mon_10, year_1, year_10;
  logic       year_wrap, load_err;

  int n_vec;
  int n_err;

  // Reference state
  int m_day, m_mon, m_year;
  bit m_wrap, m_err;

  calendar_bcd_counter #(
    .RST_YEAR(8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .day_inc  (day_inc),
    .load     (load),
    .ld_day   (ld_day),
    .ld_mon   (ld_mon),
    .ld_year  (ld_year),
    .day_1    (day_1),
    .day_10   (day_10),
    .mon_1    (mon_1),
    .mon_10   (mon_10),
    .year_1   (year_1),
    .year_10  (year_10),
    .year_wrap(year_wrap),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic bit leap(input int yr);
`ifdef CAL_LEAP_EN
    return (yr % 4) == 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int dim(input int mon, input int yr);
    case (mon)
      2:             return leap(yr) ? 29 : 28;
      4, 6, 9, 11:   return 30;
      default:       return 31;
    endcase
  endfunction

  task automatic model_reset();
    m_day = 1; m_mon = 1; m_year = 0; m_wrap = 0; m_err = 0;
  endtask

  task automatic model_step(input bit ld, input bit inc,
                            input logic [7:0] d, input logic [7:0] m, input logic [7:0] y);
    bit ok;
    int dv, mv, yv;
    m_wrap = 0;
    m_err  = 0;
    if (ld) begin
      ok = (d[7:4] <= 9) && (d[3:0] <= 9) && (m[7:4] <= 9) && (m[3:0] <= 9) &&
           (y[7:4] <= 9) && (y[3:0] <= 9);
      dv = int'(d[7:4]) * 10 + int'(d[3:0]);
      mv = int'(m[7:4]) * 10 + int'(m[3:0]);
      yv = int'(y[7:4]) * 10 + int'(y[3:0]);
      if (ok) ok = (mv >= 1) && (mv <= 12);
      if (ok) ok = (dv >= 1) && (dv <= dim(mv, yv));
      if (ok) begin
        m_day = dv; m_mon = mv; m_year = yv;
      end else begin
        m_err = 1;
      end
    end else if (inc) begin
      m_day++;
      if (m_day > dim(m_mon, m_year)) begin
        m_day = 1;
        m_mon++;
        if (m_mon > 12) begin
          m_mon = 1;
          m_year++;
          if (m_year > 99) begin
            m_year = 0;
            m_wrap = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".day"},  {24'd0, day_10, day_1},   {24'd0, to_bcd(m_day)});
    check({tag, ".mon"},  {24'd0, mon_10, mon_1},   {24'd0, to_bcd(m_mon)});
    check({tag, ".year"}, {24'd0, year_10, year_1}, {24'd0, to_bcd(m_year)});
    check({tag, ".wrap"}, {31'd0, year_wrap},       {31'd0, m_wrap});
    check({tag, ".err"},  {31'd0, load_err},        {31'd0, m_err});
  endtask

  // This task is entered at a falling edge and returns at the next falling edge.
  task automatic apply(input string tag, input bit ld, input bit inc,
                       input logic [7:0] d, input logic [7:0] m, input logic [7:0] y);
    load = ld; day_inc = inc; ld_day = d; ld_mon = m; ld_year = y;
    @(posedge clk);
    model_step(ld, inc, d, m, y);
    #1;
    check_all(tag);
    load = 0; day_inc = 0;
    @(negedge clk);
  endtask

  task automatic load_then_inc(input string tag, input logic [7:0] d, input logic [7:0] m,
                               input logic [7:0] y);
    apply({tag, ".ld"}, 1, 0, d, m, y);
    apply({tag, ".inc"}, 0, 1, 8'h00, 8'h00, 8'h00);
    apply({tag, ".hold"}, 0, 0, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 0; day_inc = 0; load = 0; ld_day = 0; ld_mon = 0; ld_year = 0;
    model_reset();
    #12;
    check_all("rst");
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 10; i++) apply("idle", 0, 0, 8'h00, 8'h00, 8'h00);

    load_then_inc("feb23", 8'h28, 8'h02, 8'h23);
    load_then_inc("feb24", 8'h28, 8'h02, 8'h24);
    load_then_inc("dec99", 8'h31, 8'h12, 8'h99);
    load_then_inc("apr15", 8'h30, 8'h04, 8'h15);
    load_then_inc("oct15", 8'h09, 8'h10, 8'h15);

    apply("bad0", 1, 0, 8'h31, 8'h04, 8'h10);
    apply("bad0h", 0, 0, 8'h00, 8'h00, 8'h00);
    apply("bad1", 1, 0, 8'h00, 8'h05, 8'h10);
    apply("bad2", 1, 0, 8'h15, 8'h13, 8'h10);
    apply("bad3", 1, 1, 8'h1A, 8'h01, 8'h10);
    apply("bad3h", 0, 0, 8'h00, 8'h00, 8'h00);
    apply("feb29_23", 1, 0, 8'h29, 8'h02, 8'h23);
    apply("feb29_24", 1, 0, 8'h29, 8'h02, 8'h24);

    apply("ldinc", 1, 1, 8'h05, 8'h06, 8'h07);
    apply("ldinch", 0, 0, 8'h00, 8'h00, 8'h00);

    apply("y24", 1, 0, 8'h01, 8'h01, 8'h24);
    for (int i = 0; i < 366; i++) apply("run366", 0, 1, 8'h00, 8'h00, 8'h00);
    apply("run366h", 0, 0, 8'h00, 8'h00, 8'h00);

    for (int i = 0; i < 600; i++) begin
      bit ld, inc;
      logic [7:0] d, m, y;
      ld  = ($urandom_range(0, 7) == 0);
      inc = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0: begin d = 8'($urandom); m = 8'($urandom); y = 8'($urandom); end
        1: begin d = 8'h29; m = 8'h02; y = to_bcd($urandom_range(0, 99)); end
        default: begin
          d = to_bcd($urandom_range(0, 31));
          m = to_bcd($urandom_range(0, 13));
          y = to_bcd($urandom_range(0, 99));
        end
      endcase
      apply("rand", ld, inc, d, m, y);
    end

    // Asynchronous reset in the middle of a run of increments
    for (int i = 0; i < 5; i++) apply("prerst", 0, 1, 8'h00, 8'h00, 8'h00);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check_all("arst");
    day_inc = 1;
    @(posedge clk);
    #1;
    check_all("arst_hold");
    @(negedge clk);
    rst_n = 1;
    apply("rel", 0, 1, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 40; i++) apply("postrst", 0, 1, 8'h00, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/calendar_bcd_counter.md
# calendar_bcd_counter

Day/month/year calendar counter for the century clock, feeding the display mux when the date view is selected. Advances one day per `day_inc` pulse (issued by the hour stage on its 23→00 rollover) and holds six BCD digits spanning 01/01/00 to 31/12/99. It applies the correct month lengths and the 2-digit leap-year rule. It also accepts a validated parallel date load for setting.

## Interface
- `RST_YEAR` (default 8'h00): BCD year (two digits) loaded at reset; must be a valid BCD value.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `day_inc` in 1: one-cycle pulse; advance date by one day.
- `load` in 1: one-cycle pulse; load `ld_day`/`ld_mon`/`ld_year`.
- `ld_day` in 8: BCD day, {tens, ones}.
- `ld_mon` in 8: BCD month, {tens, ones}.
- `ld_year` in 8: BCD year, {tens, ones}.
- `day_1`, `day_10`, `mon_1`, `mon_10`, `year_1`, `year_10` out 4 each: registered BCD digits.
- `year_wrap` out 1: one-cycle pulse on the 99→00 rollover.
- `load_err` out 1: one-cycle pulse when a load is rejected.

## Operation
- Reset values: date 01/01 (`day_10`=0, `day_1`=1, `mon_10`=0, `mon_1`=1); year = `RST_YEAR`; `year_wrap`=0; `load_err`=0.
- Month length is combinational from the current month and year:
  - 31 days: months 1, 3, 5, 7, 8, 10, 12.
  - 30 days: months 4, 6, 9, 11.
  - February: 28 days, or 29 in a leap year (see Configuration).
- Leap year (2-digit, exact for 2000–2099):
  - `year_10` even and `year_1` ∈ {0, 4, 8}, or
  - `year_10` odd and `year_1` ∈ {2, 6}.
- Priority per cycle: `load` > `day_inc` > hold.
- Day advance:
  - Day < month length: BCD increment; if `day_1`=9, set `day_1`=0 and increment `day_10`.
  - Day = month length: day←01, then month advance.
- Month advance:
  - Month < 12: BCD increment (09→10).
  - Month = 12: month←01, then year advance.
- Year advance: BCD increment; 99→00 with `year_wrap` asserted.
- Load validation:
  - Every nibble ≤ 9.
  - Month 01–12.
  - Day between 01 and the month length, evaluated against `ld_year`, not the current year.
  - Valid: all six digits update together.
  - Invalid: all registers unchanged and `load_err` pulses; a coincident `day_inc` is dropped.
- All outputs update together; no intermediate or partial date is ever visible.

## Timing
- Fully synchronous except reset; all outputs are registered.
- Latency: the date changes on the same rising edge that samples `day_inc` or `load` high. `year_wrap` and `load_err` are high for exactly the cycle after that edge.
- `day_inc` held high for N cycles advances N days; no edge detection is performed.
- `load` and `day_inc` in the same cycle: load only (valid or not); the increment is lost.
- Reset asserted mid-operation: outputs go to reset values immediately and asynchronously. Release is sampled on the next `clk` edge; a `day_inc` present in that cycle is honoured.
- The critical path (leap detection → month length → compare → BCD increment) must close in one cycle.

## Configuration
- `CAL_LEAP_EN` defined: February has 29 days in leap years per the rule above; loading 29/02 in a leap year is valid.
- `CAL_LEAP_EN` undefined: February always has 28 days; no leap logic is synthesized; loading 29/02 in any year raises `load_err`.

## Test plan
- Reset, `RST_YEAR`=8'h00 → digits 01/01/00, `year_wrap`=0, `load_err`=0; hold 10 cycles with no inputs → unchanged.
- Load 28/02/23 then `day_inc` → 01/03/23. Load 28/02/24 then `day_inc` → 29/02/24 with `CAL_LEAP_EN` defined, 01/03/24 without.
- Load 31/12/99 then `day_inc` → 01/01/00, `year_wrap` high for exactly 1 cycle. Load 30/04/15 then `day_inc` → 01/05/15. Load 09/10/15 then `day_inc` → 10/10/15.
- Load 31/04/10, 00/05/10, 15/13/10, and 1A/01/10 in turn → `load_err` pulses once each; the date is unchanged.
- `load`=1 with 05/06/07 and `day_inc`=1 in the same cycle → 05/06/07 (not 06/06/07). Hold `day_inc` high 366 cycles from 01/01/24 (`CAL_LEAP_EN` defined) → 01/01/25.
- Assert `rst_n` low mid-sequence while `day_inc` pulses → outputs go to 01/01/`RST_YEAR` without waiting for a clock edge; after release, pulses resume from 01/01.
